// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use bubble insertion, hold and flush.
// Define IDEX_BUBBLE_COUNT_EN to make bubble_count a live counter; otherwise it is tied to zero.
module id_ex_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic [DATA_W-1:0]  id_pc_plus4,
    input  logic [DATA_W-1:0]  id_rs_data1,
    input  logic [DATA_W-1:0]  id_rs_data2,
    input  logic [DATA_W-1:0]  id_imm_ext,
    input  logic [REG_W-1:0]   id_read_register1,
    input  logic [REG_W-1:0]   id_read_register2,
    input  logic [REG_W-1:0]   id_write_register,
    input  logic               id_regwrite,
    input  logic               id_memread,
    input  logic               id_memwrite,
    input  logic               id_alusrc1,
    input  logic               id_alusrc2,
    input  logic [1:0]         id_memtoreg,
    input  logic [ALUOP_W-1:0] id_aluctrl,
    output logic [DATA_W-1:0]  ex_pc_plus4,
    output logic [DATA_W-1:0]  ex_rs_data1,
    output logic [DATA_W-1:0]  ex_rs_data2,
    output logic [DATA_W-1:0]  ex_imm_ext,
    output logic [REG_W-1:0]   ex_read_register1,
    output logic [REG_W-1:0]   ex_read_register2,
    output logic [REG_W-1:0]   ex_write_register,
    output logic               ex_regwrite,
    output logic               ex_memread,
    output logic               ex_memwrite,
    output logic               ex_alusrc1,
    output logic               ex_alusrc2,
    output logic [1:0]         ex_memtoreg,
    output logic [ALUOP_W-1:0] ex_aluctrl,
    output logic               ex_valid,
    output logic               hazard_stall,
    output logic [31:0]        bubble_count
);
    logic load_bubble;
    assign hazard_stall = ex_memread & ex_valid & (ex_write_register != '0)
                        & ((ex_write_register == id_read_register1) | (ex_write_register == id_read_register2))
                        & ~flush & ~stall;
    assign load_bubble = flush | hazard_stall;
    // A bubble is identical to the reset image, so register numbers never match in forwarding.
    always_ff @(posedge clk) begin
        if (reset || load_bubble) begin
            ex_pc_plus4       <= '0;
            ex_rs_data1       <= '0;
            ex_rs_data2       <= '0;
            ex_imm_ext        <= '0;
            ex_read_register1 <= '0;
            ex_read_register2 <= '0;
            ex_write_register <= '0;
            ex_regwrite       <= 1'b0;
            ex_memread        <= 1'b0;
            ex_memwrite       <= 1'b0;
            ex_alusrc1        <= 1'b0;
            ex_alusrc2        <= 1'b0;
            ex_memtoreg       <= '0;
            ex_aluctrl        <= '0;
            ex_valid          <= 1'b0;
        end else if (!stall) begin
            ex_pc_plus4       <= id_pc_plus4;
            ex_rs_data1       <= id_rs_data1;
            ex_rs_data2       <= id_rs_data2;
            ex_imm_ext        <= id_imm_ext;
            ex_read_register1 <= id_read_register1;
            ex_read_register2 <= id_read_register2;
            ex_write_register <= id_write_register;
            ex_regwrite       <= id_regwrite;
            ex_memread        <= id_memread;
            ex_memwrite       <= id_memwrite;
            ex_alusrc1        <= id_alusrc1;
            ex_alusrc2        <= id_alusrc2;
            ex_memtoreg       <= id_memtoreg;
            ex_aluctrl        <= id_aluctrl;
            ex_valid          <= 1'b1;
        end
    end
`ifdef IDEX_BUBBLE_COUNT_EN
    logic [31:0] count;
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load_bubble)
            count <= count + 32'd1;
    end
    assign bubble_count = count;
`else
    assign bubble_count = 32'h0;
`endif
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed vector table plus randomized run against a reference model.
module tb_id_ex_stage_reg;
    typedef struct packed {
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rr1, rr2, wr;
        logic        rw, mr, mw, as1, as2;
        logic [1:0]  mtr;
        logic [4:0]  alu;
        logic        valid;
    } rec_t;

    typedef struct {
        logic        r, s, f, mr;
        logic [4:0]  rr1, rr2, wr;
        logic [31:0] d1;
        logic        chk_hz, hz, valid;
        logic [4:0]  ewr, err2;
        logic [31:0] ed1, ebc;
    } vec_t;

    logic clk = 1'b0;
    logic reset, stall, flush;
    rec_t id, act, m;
    logic [31:0] mbc;
    logic mhz;
    int checks = 0, errors = 0;

    logic [31:0] ex_pc_plus4, ex_rs_data1, ex_rs_data2, ex_imm_ext, bubble_count;
    logic [4:0]  ex_read_register1, ex_read_register2, ex_write_register, ex_aluctrl;
    logic        ex_regwrite, ex_memread, ex_memwrite, ex_alusrc1, ex_alusrc2, ex_valid, hazard_stall;
    logic [1:0]  ex_memtoreg;

    assign act = {ex_pc_plus4, ex_rs_data1, ex_rs_data2, ex_imm_ext, ex_read_register1,
                  ex_read_register2, ex_write_register, ex_regwrite, ex_memread, ex_memwrite,
                  ex_alusrc1, ex_alusrc2, ex_memtoreg, ex_aluctrl, ex_valid};

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_pc_plus4(id.pc), .id_rs_data1(id.d1), .id_rs_data2(id.d2), .id_imm_ext(id.imm),
        .id_read_register1(id.rr1), .id_read_register2(id.rr2), .id_write_register(id.wr),
        .id_regwrite(id.rw), .id_memread(id.mr), .id_memwrite(id.mw),
        .id_alusrc1(id.as1), .id_alusrc2(id.as2), .id_memtoreg(id.mtr), .id_aluctrl(id.alu),
        .ex_pc_plus4(ex_pc_plus4), .ex_rs_data1(ex_rs_data1), .ex_rs_data2(ex_rs_data2),
        .ex_imm_ext(ex_imm_ext), .ex_read_register1(ex_read_register1),
        .ex_read_register2(ex_read_register2), .ex_write_register(ex_write_register),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_alusrc1(ex_alusrc1), .ex_alusrc2(ex_alusrc2), .ex_memtoreg(ex_memtoreg),
        .ex_aluctrl(ex_aluctrl), .ex_valid(ex_valid), .hazard_stall(hazard_stall),
        .bubble_count(bubble_count)
    );

    task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    function automatic logic [31:0] bc_exp(input logic [31:0] n);
`ifdef IDEX_BUBBLE_COUNT_EN
        return n;
`else
        return 32'h0 & n;
`endif
    endfunction

    function automatic rec_t rand_id();
        rec_t r;
        r.pc = $urandom; r.d1 = $urandom; r.d2 = $urandom; r.imm = $urandom;
        r.rr1 = 5'($urandom_range(0, 3));
        r.rr2 = 5'($urandom_range(0, 3));
        r.wr  = 5'($urandom_range(0, 3));
        r.rw = 1'($urandom); r.mr = 1'($urandom); r.mw = 1'($urandom);
        r.as1 = 1'($urandom); r.as2 = 1'($urandom);
        r.mtr = 2'($urandom); r.alu = 5'($urandom);
        r.valid = 1'b0;
        return r;
    endfunction

    // Reference: an instruction in EX that is a real load to a nonzero register
    // read by the ID instruction must be separated from it by one bubble.
    task automatic step(output logic hz);
        #3;
        hz  = hazard_stall;
        mhz = m.valid && m.mr && m.wr != 0 && (m.wr == id.rr1 || m.wr == id.rr2) && !flush && !stall;
        @(posedge clk);
        if (reset) begin
            m = '0; mbc = 0;
        end else if (flush || mhz) begin
            m = '0; mbc = mbc + 1;
        end else if (!stall) begin
            m = id; m.valid = 1'b1;
        end
        #1;
    endtask

    initial begin
        vec_t v[$];
        logic hz;
        m = '0; mbc = 0;
        reset = 1; stall = 0; flush = 0; id = rand_id();
        //                r  s  f  mr rr1 rr2 wr  d1            chk hz val ewr err2 ed1          ebc
        v.push_back(vec_t'{1, 0, 0, 1, 7,  7,  7,  32'h1234,     0, 0, 0,  0,  0,  32'h0,       0});
        v.push_back(vec_t'{1, 0, 0, 1, 7,  7,  7,  32'h1234,     1, 0, 0,  0,  0,  32'h0,       0});
        v.push_back(vec_t'{0, 0, 0, 0, 1,  2,  5,  32'hDEADBEEF, 1, 0, 1,  5,  2,  32'hDEADBEEF, 0});
        v.push_back(vec_t'{0, 0, 0, 1, 5,  0,  8,  32'h11,       1, 0, 1,  8,  0,  32'h11,      0});
        v.push_back(vec_t'{0, 0, 0, 0, 3,  8,  9,  32'h22,       1, 1, 0,  0,  0,  32'h0,       1});
        v.push_back(vec_t'{0, 0, 0, 0, 3,  8,  9,  32'h22,       1, 0, 1,  9,  8,  32'h22,      1});
        v.push_back(vec_t'{0, 0, 0, 1, 0,  0,  0,  32'h33,       1, 0, 1,  0,  0,  32'h33,      1});
        v.push_back(vec_t'{0, 0, 0, 0, 0,  0,  10, 32'h44,       1, 0, 1,  10, 0,  32'h44,      1});
        v.push_back(vec_t'{0, 0, 0, 1, 1,  2,  6,  32'h55,       1, 0, 1,  6,  2,  32'h55,      1});
        v.push_back(vec_t'{0, 0, 0, 1, 6,  0,  6,  32'h66,       1, 1, 0,  0,  0,  32'h0,       2});
        v.push_back(vec_t'{0, 0, 0, 1, 6,  0,  6,  32'h66,       1, 0, 1,  6,  0,  32'h66,      2});
        v.push_back(vec_t'{0, 0, 0, 0, 0,  6,  11, 32'h77,       1, 1, 0,  0,  0,  32'h0,       3});
        v.push_back(vec_t'{0, 0, 0, 0, 0,  6,  11, 32'h77,       1, 0, 1,  11, 6,  32'h77,      3});
        v.push_back(vec_t'{0, 1, 0, 0, 11, 0,  12, 32'h88,       1, 0, 1,  11, 6,  32'h77,      3});
        v.push_back(vec_t'{0, 1, 0, 0, 0,  0,  13, 32'h99,       1, 0, 1,  11, 6,  32'h77,      3});
        v.push_back(vec_t'{0, 1, 0, 1, 1,  2,  14, 32'hAA,       1, 0, 1,  11, 6,  32'h77,      3});
        v.push_back(vec_t'{0, 0, 0, 1, 1,  2,  14, 32'hAA,       1, 0, 1,  14, 2,  32'hAA,      3});
        v.push_back(vec_t'{0, 1, 1, 0, 14, 0,  15, 32'hBB,       1, 0, 0,  0,  0,  32'h0,       4});
        v.push_back(vec_t'{0, 0, 1, 0, 1,  1,  16, 32'hCC,       1, 0, 0,  0,  0,  32'h0,       5});
        v.push_back(vec_t'{0, 0, 0, 0, 1,  1,  17, 32'hDD,       1, 0, 1,  17, 1,  32'hDD,      5});
        v.push_back(vec_t'{1, 1, 0, 0, 1,  1,  20, 32'hEE,       1, 0, 0,  0,  0,  32'h0,       0});
        v.push_back(vec_t'{0, 0, 0, 1, 0,  0,  3,  32'h1,        1, 0, 1,  3,  0,  32'h1,       0});
        v.push_back(vec_t'{0, 1, 0, 0, 3,  0,  4,  32'h2,        1, 0, 1,  3,  0,  32'h1,       0});
        v.push_back(vec_t'{0, 0, 0, 0, 3,  0,  4,  32'h2,        1, 1, 0,  0,  0,  32'h0,       1});
        v.push_back(vec_t'{0, 0, 0, 0, 3,  0,  4,  32'h2,        1, 0, 1,  4,  0,  32'h2,       1});
        foreach (v[i]) begin
            id = rand_id();
            id.rw = 1'b1; id.mr = v[i].mr;
            id.rr1 = v[i].rr1; id.rr2 = v[i].rr2; id.wr = v[i].wr; id.d1 = v[i].d1;
            reset = v[i].r; stall = v[i].s; flush = v[i].f;
            step(hz);
            if (v[i].chk_hz) chk($sformatf("vec%0d hazard_stall", i), hz, v[i].hz);
            chk($sformatf("vec%0d ex_valid", i), ex_valid, v[i].valid);
            chk($sformatf("vec%0d ex_regwrite", i), ex_regwrite, v[i].valid);
            chk($sformatf("vec%0d ex_write_register", i), ex_write_register, v[i].ewr);
            chk($sformatf("vec%0d ex_read_register2", i), ex_read_register2, v[i].err2);
            chk($sformatf("vec%0d ex_rs_data1", i), ex_rs_data1, v[i].ed1);
            chk($sformatf("vec%0d bubble_count", i), bubble_count, bc_exp(v[i].ebc));
            if (!v[i].valid) chk($sformatf("vec%0d bubble image", i), act, '0);
        end
        for (int n = 0; n < 2000; n++) begin
            id = rand_id();
            reset = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 5) == 0);
            step(hz);
            chk($sformatf("rand%0d hazard_stall", n), hz, mhz);
            chk($sformatf("rand%0d ex state", n), act, m);
            chk($sformatf("rand%0d bubble_count", n), bubble_count, bc_exp(mbc));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
